move_input_ctrl: RTL and testbench
==================================

MOVE_INPUT_CTRL -- requirements
Module: move_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 65536: consecutive identical synchronized samples required to accept a new button level.
REQ-002 Parameter CNT_W, default 16: width of move_count.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low (low = reset).
REQ-005 btn_up, btn_right, btn_down, btn_left  input  1 each  raw, asynchronous, active-high direction buttons.
REQ-006 btn_rst  input  1  raw, asynchronous, active-high new-game button.
REQ-007 move_req  output  1  a move is pending; dir is valid while high.
REQ-008 move_ack  input  1  the game controller has consumed the move; sampled on the rising clk edge.
REQ-009 dir  output  2  move direction: 0 = up, 1 = right, 2 = down, 3 = left.
REQ-010 game_rst  output  1  one-cycle pulse requesting a board and score reset.
REQ-011 move_count  output  CNT_W  number of acknowledged moves.

Function
REQ-012 Each of the 5 raw inputs SHALL pass through a 2-flop synchronizer and then a debouncer.
REQ-013 Debouncer: the counter clears whenever the synchronized sample equals the debounced level; otherwise it increments; on reaching DEBOUNCE_CYCLES-1 with a still-differing sample, the debounced level toggles and the counter clears.
REQ-014 A press SHALL be a rising edge of the debounced level (1-cycle detect); releases generate no event.
REQ-015 FSM states: IDLE, REQ, WAIT_REL.
REQ-016 IDLE -> REQ on any direction press: latch dir and assert move_req on the next edge.
REQ-017 Simultaneous direction presses in IDLE SHALL be resolved by fixed priority up > right > down > left.
REQ-018 REQ: move_req and dir are held stable until move_ack is sampled high; then move_req deasserts, move_count increments (wrapping at 2^CNT_W), and the FSM goes to WAIT_REL.
REQ-019 REQ: direction presses are ignored; move_ack sampled outside REQ is ignored.
REQ-020 WAIT_REL -> IDLE on the first cycle all four debounced direction levels are low; presses while in WAIT_REL are discarded, never queued.
REQ-021 A btn_rst press SHALL pulse game_rst high for exactly 1 cycle in any state.
REQ-022 If btn_rst is pressed while in REQ, move_req drops the next cycle, move_count is unchanged, and the FSM goes to WAIT_REL.
REQ-023 If btn_rst and a direction are pressed in the same IDLE cycle, game_rst wins and the FSM goes to WAIT_REL with no move_req.
REQ-024 dir SHALL hold its last latched value while move_req is low.
REQ-025 Latency: a clean raw press reaches move_req high DEBOUNCE_CYCLES+3 rising edges after the first edge sampling it high.
REQ-026 move_ack arriving on the same edge that move_req rises SHALL NOT be honoured; move_req must be sampled high first.

Reset
REQ-027 While rst is low: move_req=0, dir=0, game_rst=0, move_count=0, FSM=IDLE, synchronizers, debounced levels and debounce counters all 0.
REQ-028 Reset mid-REQ SHALL drop move_req immediately (asynchronously) without incrementing move_count.
REQ-029 After rst deasserts, a button already held high SHALL produce a press after debounce.

Structure
REQ-030 Package game_pkg SHALL hold DIR_UP/RIGHT/DOWN/LEFT constants, the FSM state type, and the default DEBOUNCE_CYCLES.
REQ-031 One sub-module, button_debounce (synchronizer + debouncer + rise-pulse output), SHALL be instantiated 5 times.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 btn_right held high 20 cycles, move_ack pulsed 2 cycles after move_req -> move_req rises 7 edges after the press, dir=1, move_count=1, single request only.
REQ-033 btn_up toggled every cycle for 30 cycles -> move_req never asserts, debounced level stays 0.
REQ-034 btn_down and btn_left rise on the same cycle -> dir=2.
REQ-035 btn_left pressed during REQ, then released before ack -> no second move_req after ack; move_count=1.
REQ-036 btn_rst pressed while in REQ -> game_rst high for exactly 1 cycle, move_req drops, move_count unchanged.
REQ-037 rst driven low mid-REQ with move_count=5 -> all outputs 0 immediately; btn_up still held after rst release -> new move_req with dir=0.

Source files
------------

// File: rtl/move_input_ctrl_pkg.sv
// Shared constants and types for the move input controller: direction codes,
// FSM state encoding and the default debounce length.
package game_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 65536;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE     = 2'd0;
   localparam state_t ST_REQ      = 2'd1;
   localparam state_t ST_WAIT_REL = 2'd2;

   // Simultaneous presses resolve as up > right > down > left.
   function automatic logic [1:0] pick_dir(input logic [3:0] press);
      logic [1:0] d;
      d = DIR_LEFT;
      if (press[0])      d = DIR_UP;
      else if (press[1]) d = DIR_RIGHT;
      else if (press[2]) d = DIR_DOWN;
      return d;
   endfunction

endpackage

// File: rtl/move_input_ctrl_if.sv
// Move handshake between the input controller (master) and the game
// controller (slave), plus the new-game pulse and the move counter.
interface move_input_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             move_req;
   logic             move_ack;
   logic [1:0]       dir;
   logic             game_rst;
   logic [CNT_W-1:0] move_count;

   modport master (
      output move_req,
      output dir,
      output game_rst,
      output move_count,
      input  move_ack
   );

   modport slave (
      input  move_req,
      input  dir,
      input  game_rst,
      input  move_count,
      output move_ack
   );
endinterface

// File: rtl/move_input_ctrl_debounce.sv
// One raw button: 2-flop synchronizer, counting debouncer and a one-cycle
// pulse on each rising edge of the debounced level.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The counter only runs while the synchronized sample disagrees with the
   // accepted level; any agreeing sample restarts the qualification window.
   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = cnt_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         level_d = ~level_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      press_d = level_d & ~level_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/move_input_ctrl.sv
// Turns four debounced direction buttons and a new-game button into a
// single-move request/acknowledge handshake with a running move counter.
module move_input_ctrl
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_up,
   input  logic               btn_right,
   input  logic               btn_down,
   input  logic               btn_left,
   input  logic               btn_rst,
   move_input_ctrl_if.master  bus
);

   logic [4:0] btn_raw;
   logic [4:0] level;
   logic [4:0] press;
   logic       unused_rst_level;

   assign btn_raw          = {btn_rst, btn_left, btn_down, btn_right, btn_up};
   assign unused_rst_level = level[4];

   for (genvar i = 0; i < 5; i++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk    (clk),
         .rst    (rst),
         .btn_raw(btn_raw[i]),
         .level  (level[i]),
         .press  (press[i])
      );
   end

   state_t           state_q, state_d;
   logic             move_req_q, move_req_d;
   logic [1:0]       dir_q, dir_d;
   logic             game_rst_q, game_rst_d;
   logic [CNT_W-1:0] move_count_q, move_count_d;

   // A new-game press outranks everything: it aborts a pending move and, like
   // an acknowledged move, parks the FSM until all directions are released.
   always_comb begin
      state_d      = state_q;
      move_req_d   = move_req_q;
      dir_d        = dir_q;
      move_count_d = move_count_q;
      game_rst_d   = press[4];
      case (state_q)
         ST_IDLE: begin
            if (press[4]) begin
               state_d = ST_WAIT_REL;
            end else if (|press[3:0]) begin
               dir_d      = pick_dir(press[3:0]);
               move_req_d = 1'b1;
               state_d    = ST_REQ;
            end
         end
         ST_REQ: begin
            if (press[4]) begin
               move_req_d = 1'b0;
               state_d    = ST_WAIT_REL;
            end else if (bus.move_ack) begin
               move_req_d   = 1'b0;
               move_count_d = move_count_q + CNT_W'(1);
               state_d      = ST_WAIT_REL;
            end
         end
         ST_WAIT_REL: begin
            if (level[3:0] == 4'b0000) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            move_req_d = 1'b0;
            state_d    = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         move_req_q   <= 1'b0;
         dir_q        <= DIR_UP;
         game_rst_q   <= 1'b0;
         move_count_q <= '0;
      end else begin
         state_q      <= state_d;
         move_req_q   <= move_req_d;
         dir_q        <= dir_d;
         game_rst_q   <= game_rst_d;
         move_count_q <= move_count_d;
      end
   end

   assign bus.move_req   = move_req_q;
   assign bus.dir        = dir_q;
   assign bus.game_rst   = game_rst_q;
   assign bus.move_count = move_count_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Bench for move_input_ctrl: directed scenarios plus a randomized run, all
// checked against a behavioural model of debouncing and the move handshake.
module tb_move_input_ctrl;

   localparam int D  = 4;
   localparam int CW = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] btn;
   logic       ack;

   always #5 clk = ~clk;

   move_input_ctrl_if #(.CNT_W(CW)) bus();
   assign bus.move_ack = ack;

   move_input_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_up   (btn[0]),
      .btn_right(btn[1]),
      .btn_down (btn[2]),
      .btn_left (btn[3]),
      .btn_rst  (btn[4]),
      .bus      (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: a level is accepted once the last D synchronized samples all
   // disagree with it; the synchronizer is two edges of raw history.
   bit          hist [5][D+1];
   bit          m_lvl [5];
   bit          m_press [5];
   bit          m_req, m_wait, m_grst;
   logic [1:0]  m_dir;
   logic [CW-1:0] m_cnt;

   task automatic model_reset();
      for (int b = 0; b < 5; b++) begin
         for (int k = 0; k <= D; k++) hist[b][k] = 1'b0;
         m_lvl[b]   = 1'b0;
         m_press[b] = 1'b0;
      end
      m_req  = 1'b0;
      m_wait = 1'b0;
      m_grst = 1'b0;
      m_dir  = 2'd0;
      m_cnt  = '0;
   endtask

   task automatic model_edge();
      bit any_lvl;
      any_lvl = m_lvl[0] | m_lvl[1] | m_lvl[2] | m_lvl[3];
      m_grst  = m_press[4];
      if (m_req) begin
         if (m_press[4]) begin
            m_req  = 1'b0;
            m_wait = 1'b1;
         end else if (ack) begin
            m_req  = 1'b0;
            m_cnt  = m_cnt + 1'b1;
            m_wait = 1'b1;
         end
      end else if (m_wait) begin
         if (!any_lvl) m_wait = 1'b0;
      end else begin
         if (m_press[4]) begin
            m_wait = 1'b1;
         end else if (m_press[0] | m_press[1] | m_press[2] | m_press[3]) begin
            for (int b = 3; b >= 0; b--) if (m_press[b]) m_dir = 2'(b);
            m_req = 1'b1;
         end
      end
      for (int b = 0; b < 5; b++) begin
         bit all_diff;
         all_diff = 1'b1;
         for (int k = 1; k <= D; k++) if (hist[b][k] == m_lvl[b]) all_diff = 1'b0;
         m_press[b] = all_diff && !m_lvl[b];
         if (all_diff) m_lvl[b] = !m_lvl[b];
         for (int k = D; k >= 1; k--) hist[b][k] = hist[b][k-1];
         hist[b][0] = btn[b];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic wait_req(input int limit, output int edges);
      edges = 0;
      while (!bus.move_req && edges < limit) begin
         tick();
         edges++;
      end
   endtask

   task automatic hold_reset(input int cycles);
      rst = 1'b0;
      model_reset();
      repeat (cycles) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      btn = '0;
      ack = 1'b0;
      hold_reset(3);
      n_vec++; if (bus.move_req !== 1'b0) begin n_err++; $display("[TB] FAIL reset_move_req got %b want 0", bus.move_req); end
      n_vec++; if (bus.dir !== 2'd0) begin n_err++; $display("[TB] FAIL reset_dir got %0d want 0", bus.dir); end
      n_vec++; if (bus.game_rst !== 1'b0) begin n_err++; $display("[TB] FAIL reset_game_rst got %b want 0", bus.game_rst); end
      n_vec++; if (bus.move_count !== '0) begin n_err++; $display("[TB] FAIL reset_move_count got %0d want 0", bus.move_count); end
      repeat (3) tick();
   endtask

   task automatic test_single_press();
      int  k, rises;
      bit  seen, prev;
      logic [1:0] dir_at_req;
      k = 0; rises = 0; seen = 0; prev = 0; dir_at_req = 2'd0;
      btn[1] = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (bus.move_req && !prev) rises++;
         if (bus.move_req && !seen) begin seen = 1; k = c; dir_at_req = bus.dir; end
         prev = bus.move_req;
         ack  = (seen && c == k + 2);
      end
      ack = 1'b0;
      btn[1] = 1'b0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (bus.move_req && !prev) rises++;
         prev = bus.move_req;
      end
      n_vec++; if (k !== 7) begin n_err++; $display("[TB] FAIL press_latency got %0d edges want 7", k); end
      n_vec++; if (dir_at_req !== 2'd1) begin n_err++; $display("[TB] FAIL press_dir got %0d want 1", dir_at_req); end
      n_vec++; if (rises !== 1) begin n_err++; $display("[TB] FAIL single_request got %0d rises want 1", rises); end
      n_vec++; if (bus.move_count !== CW'(1)) begin n_err++; $display("[TB] FAIL press_count got %0d want 1", bus.move_count); end
   endtask

   task automatic test_bounce();
      int highs;
      highs = 0;
      for (int c = 0; c < 30; c++) begin
         btn[0] = ~btn[0];
         tick();
         if (bus.move_req) highs++;
      end
      btn[0] = 1'b0;
      repeat (10) begin tick(); if (bus.move_req) highs++; end
      n_vec++; if (highs !== 0) begin n_err++; $display("[TB] FAIL bounce_no_req got %0d high cycles want 0", highs); end
      n_vec++; if (bus.dir !== 2'd1) begin n_err++; $display("[TB] FAIL dir_hold got %0d want 1", bus.dir); end
   endtask

   task automatic test_simultaneous();
      int e;
      btn[2] = 1'b1;
      btn[3] = 1'b1;
      wait_req(20, e);
      n_vec++; if (bus.move_req !== 1'b1) begin n_err++; $display("[TB] FAIL simul_req timed out after %0d edges", e); end
      n_vec++; if (bus.dir !== 2'd2) begin n_err++; $display("[TB] FAIL simul_dir got %0d want 2", bus.dir); end
      ack = 1'b1; tick(); ack = 1'b0;
      btn[2] = 1'b0; btn[3] = 1'b0;
      repeat (15) tick();
      n_vec++; if (bus.move_count !== CW'(2)) begin n_err++; $display("[TB] FAIL simul_count got %0d want 2", bus.move_count); end
   endtask

   task automatic test_press_during_req();
      int  e, rises;
      bit  prev;
      rises = 0;
      btn[0] = 1'b1;
      wait_req(20, e);
      n_vec++; if (bus.move_req !== 1'b1) begin n_err++; $display("[TB] FAIL during_req_req timed out after %0d edges", e); end
      btn[3] = 1'b1;
      repeat (8) tick();
      btn[3] = 1'b0;
      btn[0] = 1'b0;
      repeat (10) tick();
      n_vec++; if (bus.move_req !== 1'b1 || bus.dir !== 2'd0) begin n_err++; $display("[TB] FAIL during_req_hold got req=%b dir=%0d want req=1 dir=0", bus.move_req, bus.dir); end
      ack = 1'b1; tick(); ack = 1'b0;
      prev = bus.move_req;
      repeat (15) begin
         tick();
         if (bus.move_req && !prev) rises++;
         prev = bus.move_req;
      end
      n_vec++; if (rises !== 0) begin n_err++; $display("[TB] FAIL during_req_no_queue got %0d rises want 0", rises); end
      n_vec++; if (bus.move_count !== CW'(3)) begin n_err++; $display("[TB] FAIL during_req_count got %0d want 3", bus.move_count); end
   endtask

   task automatic test_game_reset_in_req();
      int e, pulses;
      pulses = 0;
      btn[1] = 1'b1;
      wait_req(20, e);
      n_vec++; if (bus.move_req !== 1'b1) begin n_err++; $display("[TB] FAIL grst_req timed out after %0d edges", e); end
      btn[4] = 1'b1;
      repeat (12) begin tick(); if (bus.game_rst) pulses++; end
      n_vec++; if (bus.move_req !== 1'b0) begin n_err++; $display("[TB] FAIL grst_drop_req got %b want 0", bus.move_req); end
      btn[4] = 1'b0;
      btn[1] = 1'b0;
      repeat (15) begin tick(); if (bus.game_rst) pulses++; end
      n_vec++; if (pulses !== 1) begin n_err++; $display("[TB] FAIL grst_pulse got %0d cycles want 1", pulses); end
      n_vec++; if (bus.move_count !== CW'(3)) begin n_err++; $display("[TB] FAIL grst_count got %0d want 3", bus.move_count); end
   endtask

   task automatic test_random();
      int hold [5];
      for (int b = 0; b < 5; b++) hold[b] = 0;
      for (int c = 0; c < 600; c++) begin
         for (int b = 0; b < 5; b++) begin
            if (hold[b] == 0) begin
               btn[b]  = (b == 4) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
               hold[b] = $urandom_range(1, 10);
            end else begin
               hold[b]--;
            end
         end
         ack = ($urandom_range(0, 3) == 0);
         tick();
         n_vec++; if (bus.move_req !== m_req) begin n_err++; $display("[TB] FAIL rand_move_req cycle %0d got %b want %b", c, bus.move_req, m_req); end
         n_vec++; if (bus.dir !== m_dir) begin n_err++; $display("[TB] FAIL rand_dir cycle %0d got %0d want %0d", c, bus.dir, m_dir); end
         n_vec++; if (bus.game_rst !== m_grst) begin n_err++; $display("[TB] FAIL rand_game_rst cycle %0d got %b want %b", c, bus.game_rst, m_grst); end
         n_vec++; if (bus.move_count !== m_cnt) begin n_err++; $display("[TB] FAIL rand_move_count cycle %0d got %0d want %0d", c, bus.move_count, m_cnt); end
      end
      btn = '0;
      ack = 1'b0;
      repeat (20) tick();
   endtask

   task automatic test_reset_mid_req();
      int e;
      hold_reset(2);
      for (int m = 0; m < 5; m++) begin
         btn[m % 4] = 1'b1;
         wait_req(20, e);
         n_vec++; if (bus.move_req !== 1'b1) begin n_err++; $display("[TB] FAIL prep_move %0d timed out after %0d edges", m, e); end
         ack = 1'b1; tick(); ack = 1'b0;
         btn[m % 4] = 1'b0;
         repeat (15) tick();
      end
      n_vec++; if (bus.move_count !== CW'(5)) begin n_err++; $display("[TB] FAIL prep_count got %0d want 5", bus.move_count); end
      btn[0] = 1'b1;
      wait_req(20, e);
      rst = 1'b0;
      model_reset();
      #1;
      n_vec++; if (bus.move_req !== 1'b0) begin n_err++; $display("[TB] FAIL async_rst_req got %b want 0", bus.move_req); end
      n_vec++; if (bus.move_count !== '0) begin n_err++; $display("[TB] FAIL async_rst_count got %0d want 0", bus.move_count); end
      n_vec++; if (bus.dir !== 2'd0 || bus.game_rst !== 1'b0) begin n_err++; $display("[TB] FAIL async_rst_outs got dir=%0d grst=%b want 0 0", bus.dir, bus.game_rst); end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      wait_req(20, e);
      n_vec++; if (e !== 7) begin n_err++; $display("[TB] FAIL held_after_rst got %0d edges want 7", e); end
      n_vec++; if (bus.dir !== 2'd0) begin n_err++; $display("[TB] FAIL held_after_rst_dir got %0d want 0", bus.dir); end
      ack = 1'b1; tick(); ack = 1'b0;
      btn[0] = 1'b0;
      repeat (15) tick();
      n_vec++; if (bus.move_count !== CW'(1)) begin n_err++; $display("[TB] FAIL held_after_rst_count got %0d want 1", bus.move_count); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b0;
      btn = '0;
      ack = 1'b0;
      test_reset();
      test_single_press();
      test_bounce();
      test_simultaneous();
      test_press_during_req();
      test_game_reset_in_req();
      test_random();
      test_reset_mid_req();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
